// File: rtl/moxie_wb_arbiter_if.sv
// Bundles the two core-side Wishbone master ports, the shared memory-side
// port and the grant vector of moxie_wb_arbiter.
interface moxie_wb_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    // Core side, {D,I} packing, index 0 = instruction fetch, 1 = data
    logic [1:0]      m_cyc_i;
    logic [1:0]      m_stb_i;
    logic [1:0]      m_we_i;
    logic [2*SW-1:0] m_sel_i;
    logic [2*AW-1:0] m_adr_i;
    logic [2*DW-1:0] m_dat_i;
    logic [DW-1:0]   m_dat_o;
    logic [1:0]      m_ack_o;
    logic [1:0]      m_err_o;

    // Memory side
    logic            s_cyc_o;
    logic            s_stb_o;
    logic            s_we_o;
    logic [SW-1:0]   s_sel_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i;
    logic            s_err_i;

    logic [1:0]      gnt_o;

    // Arbiter view
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output gnt_o
    );

    // Environment view: the two masters plus the memory slave
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  gnt_o
    );
endinterface

// File: rtl/moxie_wb_arbiter.sv
// Two-master Wishbone arbiter: data master has priority, fetch master gets a
// starvation guard, and a watchdog errors out transfers the slave ignores.
module moxie_wb_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    moxie_wb_arbiter_if.slave bus
);
    localparam int SW = DW / 8;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WDOG_LAST  = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_e;

    state_e     st_q, st_d;
    logic [1:0] gnt_q, gnt_d;
    logic [3:0] starve_q, starve_d;
    logic [7:0] wdog_q, wdog_d;

    logic       owned;
    logic       own_idx;
    logic       own_stb;
    logic       timeout;
    logic [1:0] ack_vec;
    logic [1:0] err_vec;

    assign owned   = (st_q != IDLE);
    assign own_idx = (st_q == OWN_D);
    assign own_stb = owned & bus.m_stb_i[own_idx];

    // wdog_q holds completed silent strobe cycles; this cycle would be number TIMEOUT
    assign timeout = (TIMEOUT != 0) && own_stb && !bus.s_ack_i && !bus.s_err_i
                     && (wdog_q == WDOG_LAST);

    // Slave-side mux follows the registered owner
    assign bus.s_cyc_o = owned & bus.m_cyc_i[own_idx];
    assign bus.s_stb_o = own_stb & ~timeout;
    assign bus.s_we_o  = owned & bus.m_we_i[own_idx];
    assign bus.s_sel_o = !owned ? '0 :
                         own_idx ? bus.m_sel_i[2*SW-1:SW] : bus.m_sel_i[SW-1:0];
    assign bus.s_adr_o = !owned ? '0 :
                         own_idx ? bus.m_adr_i[2*AW-1:AW] : bus.m_adr_i[AW-1:0];
    assign bus.s_dat_o = !owned ? '0 :
                         own_idx ? bus.m_dat_i[2*DW-1:DW] : bus.m_dat_i[DW-1:0];

    assign bus.m_dat_o = bus.s_dat_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            // err dominates ack when the slave raises both
            assign ack_vec[gi] = gnt_q[gi] & bus.s_ack_i & ~bus.s_err_i;
            assign err_vec[gi] = gnt_q[gi] & (bus.s_err_i | timeout);
        end
    endgenerate

    assign bus.m_ack_o = ack_vec;
    assign bus.m_err_o = err_vec;
    assign bus.gnt_o   = gnt_q;

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE: begin
                if (bus.m_cyc_i[1] && !(starve_q == STARVE_MAX && bus.m_cyc_i[0]))
                    st_d = OWN_D;
                else if (bus.m_cyc_i[0])
                    st_d = OWN_I;
            end
            OWN_I: begin
                if (!bus.m_cyc_i[0])
                    st_d = bus.m_cyc_i[1] ? OWN_D : IDLE;
            end
            OWN_D: begin
                if (!bus.m_cyc_i[1])
                    st_d = bus.m_cyc_i[0] ? OWN_I : IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d = {st_d == OWN_D, st_d == OWN_I};

        starve_d = starve_q;
        if (st_d != st_q) begin
            if (st_d == OWN_I)
                starve_d = 4'd0;
            else if (st_d == OWN_D && bus.m_cyc_i[0] && starve_q != STARVE_MAX)
                starve_d = starve_q + 4'd1;
        end

        wdog_d = wdog_q;
        if (st_d != st_q || !own_stb || bus.s_ack_i || bus.s_err_i || timeout)
            wdog_d = 8'd0;
        else if (TIMEOUT != 0)
            wdog_d = wdog_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q     <= IDLE;
            gnt_q    <= 2'b00;
            starve_q <= 4'd0;
            wdog_q   <= 8'd0;
        end else begin
            st_q     <= st_d;
            gnt_q    <= gnt_d;
            starve_q <= starve_d;
            wdog_q   <= wdog_d;
        end
    end
endmodule
